cache_fill_fsm: RTL and testbench

- Miss-handling controller between the processor's I-cache/D-cache arrays and the unified multi-cycle main memory.
- On a cache miss it fetches one 16-byte block as 8 sequential 16-bit words over a pipelined memory port.
- It writes each returned word into the data array, then writes the tag once the block is complete.
- The fetch stage or the memory stage stalls on fsm_busy.

---
 rtl/cache_pkg.sv | 19 +
 rtl/add_16bit.sv | 12 +
 rtl/fill_counter.sv | 36 +++
 rtl/cache_fill_fsm.sv | 121 ++++++++++++
 tb/tb_cache_fill_fsm.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared cache-controller definitions: block geometry and the fill/idle state type.
package cache_pkg;

  localparam int LINE_WORDS = 8;
  localparam int OFS_W      = 3;
  localparam int ADDR_W     = 16;

  // Byte-offset mask for one block of 16-bit words: OFS_W word bits plus one byte bit.
  function automatic logic [31:0] block_ofs_mask(input int ofs_w);
    return (32'd1 << (ofs_w + 1)) - 32'd1;
  endfunction

  // Shared with the write-back and arbiter logic.
  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

endpackage

// File: rtl/add_16bit.sv
// Plain address adder; the carry-out is dropped so addresses wrap at the top of memory.
module add_16bit #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/fill_counter.sv
// Small up-counter with synchronous clear and increment enable; clear takes priority.
module fill_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // Next count: clear at the start of a fill, otherwise step on each handshake.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: fetches one block word by word over a pipelined
// memory port, writes each word into the data array and the tag on the last word.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int LINE_WORDS = cache_pkg::LINE_WORDS,
  parameter int ADDR_W     = cache_pkg::ADDR_W,
  parameter int OFS_W      = cache_pkg::OFS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              mem_ready,
  input  logic              memory_data_valid,
  input  logic [15:0]       memory_data,
  output logic              fsm_busy,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [OFS_W-1:0]  fill_word_offset,
  output logic [15:0]       fill_data,
  output logic              write_tag_array,
  output logic [ADDR_W-1:0] fill_base
);

  localparam int CW = OFS_W + 1;
  localparam logic [CW-1:0]     FULL_CNT   = CW'(LINE_WORDS);
  localparam logic [CW-1:0]     LAST_CNT   = CW'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(block_ofs_mask(OFS_W));

  fill_state_e       state_q;
  fill_state_e       state_d;
  logic [ADDR_W-1:0] fill_base_q;
  logic [ADDR_W-1:0] fill_base_d;

  logic [CW-1:0]     req_cnt;
  logic [CW-1:0]     rcv_cnt;
  logic              active;
  logic              start;
  logic              req_pending;
  logic              req_fire;
  logic              rcv_fire;
  logic              last_word;
  logic [ADDR_W-1:0] req_byte_ofs;
  logic [ADDR_W-1:0] next_addr;

  // Reset forces every strobe low in the same cycle, even while the state flop still says FILL.
  assign active      = (state_q == FILL) && !rst;
  assign start       = (state_q == IDLE) && miss_detected;
  assign req_pending = active && (req_cnt < FULL_CNT);
  assign req_fire    = req_pending && mem_ready;
  assign rcv_fire    = active && (rcv_cnt < FULL_CNT) && memory_data_valid;
  assign last_word   = rcv_fire && (rcv_cnt == LAST_CNT);

  fill_counter #(.W(CW)) u_req_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start),
    .inc   (req_fire),
    .count (req_cnt)
  );

  fill_counter #(.W(CW)) u_rcv_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start),
    .inc   (rcv_fire),
    .count (rcv_cnt)
  );

  // Words are two bytes, so the request offset is the request count shifted left by one.
  assign req_byte_ofs = ADDR_W'({req_cnt, 1'b0});

  add_16bit #(.W(ADDR_W)) u_addr_add (
    .a   (fill_base_q),
    .b   (req_byte_ofs),
    .sum (next_addr)
  );

  // Next state: capture the aligned block on a miss, return to idle once the last word lands.
  always_comb begin
    state_d     = state_q;
    fill_base_d = fill_base_q;
    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          state_d     = FILL;
          fill_base_d = miss_address & ALIGN_MASK;
        end
      end
      FILL: begin
        if (last_word) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured block base, synchronously reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fill_base_q <= '0;
    end else begin
      state_q     <= state_d;
      fill_base_q <= fill_base_d;
    end
  end

  assign fsm_busy         = active;
  assign mem_read_en      = req_pending;
  assign memory_address   = active ? next_addr : '0;
  assign write_data_array = rcv_fire;
  assign fill_word_offset = rcv_fire ? rcv_cnt[OFS_W-1:0] : '0;
  assign fill_data        = memory_data;
  assign write_tag_array  = last_word;
  assign fill_base        = active ? fill_base_q : '0;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: a fixed-latency memory model feeds the DUT and
// a transaction-level model of the fill predicts every output on every cycle.
module tb_cache_fill_fsm;

  localparam int LW  = 8;
  localparam int LAT = 4;

  localparam int K_RESET  = 0;
  localparam int K_BASIC  = 1;
  localparam int K_BACKP  = 2;
  localparam int K_TOP    = 3;
  localparam int K_IGNORE = 4;
  localparam int K_RSTMID = 5;
  localparam int K_B2B    = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        mem_ready;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        mem_read_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  fill_word_offset;
  logic [15:0] fill_data;
  logic        write_tag_array;
  logic [15:0] fill_base;

  // Free-running clock.
  always #5 clk = ~clk;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .mem_ready         (mem_ready),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .mem_read_en       (mem_read_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .fill_word_offset  (fill_word_offset),
    .fill_data         (fill_data),
    .write_tag_array   (write_tag_array),
    .fill_base         (fill_base)
  );

  typedef struct {
    int          due;
    logic [15:0] addr;
  } mem_req_t;

  mem_req_t    mem_q[$];
  int          cyc;
  int          t;
  int          vectors;
  int          miscompares;
  logic        stray;

  bit          m_active;
  logic [15:0] m_base;
  int          m_issued;
  int          m_recv;
  bit          e_busy, e_rd, e_wr, e_tag;

  int          busy_count, first_busy, last_busy, tag_count, tag_at, first_write_at;
  logic [15:0] req_log[$];
  int          off_log[$];
  logic        busy_at[64];
  logic        wr_at[64];
  logic [15:0] addr_at[64];
  logic [15:0] base_at[64];

  function automatic logic [15:0] data_of(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d (test cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, t, act, exp);
    end
  endtask

  function automatic logic [15:0] req_at(input int k);
    return (req_log.size() > k) ? req_log[k] : 16'hxxxx;
  endfunction

  function automatic int off_at(input int k);
    return (off_log.size() > k) ? off_log[k] : -1;
  endfunction

  task automatic applyStimulus(input int kind, input int tc);
    rst           = 1'b0;
    miss_detected = 1'b0;
    miss_address  = 16'h0000;
    mem_ready     = 1'b1;
    stray         = 1'b0;
    case (kind)
      K_RESET:  rst = (tc < 2);
      K_BASIC:  if (tc == 0) begin miss_detected = 1'b1; miss_address = 16'h1234; end
      K_BACKP: begin
        if (tc == 0) begin miss_detected = 1'b1; miss_address = 16'h1234; end
        if (tc >= 3 && tc <= 5) mem_ready = 1'b0;
      end
      K_TOP:    if (tc == 0) begin miss_detected = 1'b1; miss_address = 16'hFFFE; end
      K_IGNORE: begin
        if (tc == 0) begin miss_detected = 1'b1; miss_address = 16'h1234; end
        if (tc == 3) begin miss_detected = 1'b1; miss_address = 16'h4000; end
        if (tc == 15) stray = 1'b1;
      end
      K_RSTMID: begin
        if (tc == 0) begin miss_detected = 1'b1; miss_address = 16'h1234; end
        if (tc == 6) rst = 1'b1;
        if (tc == 16) begin miss_detected = 1'b1; miss_address = 16'h0008; end
      end
      K_B2B: begin
        if (tc == 0) begin miss_detected = 1'b1; miss_address = 16'h1234; end
        if (tc == 13) begin miss_detected = 1'b1; miss_address = 16'h2000; end
      end
      default: ;
    endcase
  endtask

  // Expected outputs from the fill's progress: words asked for and words received so far.
  task automatic compute_expect();
    e_busy = m_active && !rst;
    e_rd   = e_busy && (m_issued < LW);
    e_wr   = e_busy && (m_recv < LW) && memory_data_valid;
    e_tag  = e_wr && (m_recv == LW - 1);
  endtask

  task automatic checkOutput();
    logic [15:0] exp_addr;
    compute_expect();
    exp_addr = m_base + 16'(2 * m_issued);
    check_value("fsm_busy", fsm_busy, e_busy);
    check_value("mem_read_en", mem_read_en, e_rd);
    check_value("write_data_array", write_data_array, e_wr);
    check_value("write_tag_array", write_tag_array, e_tag);
    check_value("fill_base", fill_base, e_busy ? m_base : 16'h0000);
    check_value("memory_address", memory_address, e_busy ? exp_addr : 16'h0000);
    check_value("fill_data_passthru", fill_data, memory_data);
    if (e_wr) begin
      check_value("fill_word_offset", fill_word_offset, m_recv);
      check_value("fill_data_word", fill_data, data_of(m_base + 16'(2 * m_recv)));
    end else if (!e_busy) begin
      check_value("fill_word_offset_idle", fill_word_offset, 0);
    end
    busy_at[t] = fsm_busy;
    wr_at[t]   = write_data_array;
    addr_at[t] = memory_address;
    base_at[t] = fill_base;
    if (fsm_busy === 1'b1) begin
      busy_count++;
      if (first_busy < 0) first_busy = t;
      last_busy = t;
    end
    if (write_tag_array === 1'b1) begin
      tag_count++;
      tag_at = t;
    end
    if (mem_read_en === 1'b1 && mem_ready) req_log.push_back(memory_address);
    if (write_data_array === 1'b1) begin
      off_log.push_back(int'(fill_word_offset));
      if (first_write_at < 0) first_write_at = t;
    end
  endtask

  task automatic model_advance();
    if (rst) begin
      m_active = 1'b0;
      m_base   = 16'h0000;
      m_issued = 0;
      m_recv   = 0;
    end else if (!m_active) begin
      if (miss_detected) begin
        m_active = 1'b1;
        m_base   = (miss_address / 16) * 16;
        m_issued = 0;
        m_recv   = 0;
      end
    end else begin
      if (e_rd && mem_ready) m_issued++;
      if (e_wr) begin
        m_recv++;
        if (m_recv == LW) m_active = 1'b0;
      end
    end
  endtask

  task automatic run_cycle(input int kind);
    logic        acc;
    logic [15:0] acc_addr;
    applyStimulus(kind, t);
    memory_data_valid = 1'b0;
    memory_data       = 16'h0000;
    if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
      memory_data_valid = 1'b1;
      memory_data       = data_of(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else if (stray) begin
      memory_data_valid = 1'b1;
      memory_data       = 16'hDEAD;
    end
    @(negedge clk);
    checkOutput();
    acc      = mem_read_en && mem_ready;
    acc_addr = memory_address;
    @(posedge clk);
    #1;
    model_advance();
    if (acc) mem_q.push_back('{due: cyc + LAT, addr: acc_addr});
    cyc++;
    t++;
  endtask

  task automatic run_test(input int kind, input int n);
    busy_count = 0; first_busy = -1; last_busy = -1;
    tag_count = 0; tag_at = -1; first_write_at = -1;
    req_log.delete();
    off_log.delete();
    for (int i = 0; i < 64; i++) begin
      busy_at[i] = 1'b0; wr_at[i] = 1'b0; addr_at[i] = 16'h0; base_at[i] = 16'h0;
    end
    t = 0;
    for (int i = 0; i < n; i++) run_cycle(kind);
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; t = 0;
    m_active = 1'b0; m_base = 16'h0; m_issued = 0; m_recv = 0;
    rst = 1'b1; miss_detected = 1'b0; miss_address = 16'h0; mem_ready = 1'b0;
    memory_data_valid = 1'b0; memory_data = 16'h0; stray = 1'b0;

    run_test(K_RESET, 3);
    check_value("reset_busy_cycles", busy_count, 0);

    run_test(K_BASIC, 16);
    check_value("basic_busy_cycles", busy_count, 12);
    check_value("basic_first_busy", first_busy, 1);
    check_value("basic_last_busy", last_busy, 12);
    check_value("basic_tag_count", tag_count, 1);
    check_value("basic_tag_cycle", tag_at, 12);
    check_value("basic_first_write", first_write_at, 5);
    check_value("basic_req_count", req_log.size(), 8);
    check_value("basic_req_first", req_at(0), 16'h1230);
    check_value("basic_req_last", req_at(7), 16'h123E);
    check_value("basic_write_count", off_log.size(), 8);
    for (int k = 0; k < 8; k++) check_value("basic_offset_seq", off_at(k), k);

    run_test(K_BACKP, 20);
    check_value("backp_busy_cycles", busy_count, 15);
    check_value("backp_addr_hold", addr_at[5], 16'h1234);
    check_value("backp_req_count", req_log.size(), 8);
    for (int k = 0; k < 8; k++) check_value("backp_req_seq", req_at(k), 16'h1230 + 16'(2 * k));
    check_value("backp_write_count", off_log.size(), 8);
    for (int k = 0; k < 8; k++) check_value("backp_offset_seq", off_at(k), k);
    check_value("backp_tag_cycle", tag_at, 15);

    run_test(K_TOP, 16);
    check_value("top_fill_base", base_at[1], 16'hFFF0);
    check_value("top_req_first", req_at(0), 16'hFFF0);
    check_value("top_req_last", req_at(7), 16'hFFFE);
    check_value("top_req_count", req_log.size(), 8);
    begin
      int zero_reqs = 0;
      foreach (req_log[k]) if (req_log[k] == 16'h0000) zero_reqs++;
      check_value("top_no_wrap_req", zero_reqs, 0);
    end

    run_test(K_IGNORE, 18);
    check_value("ignore_fill_base", base_at[12], 16'h1230);
    check_value("ignore_busy_cycles", busy_count, 12);
    check_value("ignore_write_count", off_log.size(), 8);
    check_value("ignore_stray_write", wr_at[15], 1'b0);

    run_test(K_RSTMID, 32);
    check_value("rstmid_busy_in_reset", busy_at[6], 1'b0);
    check_value("rstmid_busy_after", busy_at[7], 1'b0);
    check_value("rstmid_stale_write", wr_at[8], 1'b0);
    check_value("rstmid_write_count", off_log.size(), 9);
    check_value("rstmid_req_count", req_log.size(), 13);
    check_value("rstmid_refill_first", req_at(5), 16'h0000);
    check_value("rstmid_refill_last", req_at(12), 16'h000E);
    check_value("rstmid_tag_count", tag_count, 1);
    check_value("rstmid_tag_cycle", tag_at, 28);

    run_test(K_B2B, 30);
    check_value("b2b_busy_end_first", busy_at[12], 1'b1);
    check_value("b2b_idle_gap", busy_at[13], 1'b0);
    check_value("b2b_busy_start_second", busy_at[14], 1'b1);
    check_value("b2b_busy_cycles", busy_count, 24);
    check_value("b2b_second_req", req_at(8), 16'h2000);
    check_value("b2b_tag_count", tag_count, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
